fp_to_int_pipe: RTL and testbench
=================================

FP_TO_INT_PIPE -- requirements
Module: fp_to_int_pipe

Interface
REQ-001 SHALL have parameter LATENCY, default 3, pipeline depth in cycles (legal range 1..8).
REQ-002 SHALL have parameter OUT_WIDTH, default 32, integer result width (legal values 32 or 64).
REQ-003 SHALL have port clk, input, 1: single clock; all state on the rising edge.
REQ-004 SHALL have port areset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: pipeline advance; 0 freezes every stage.
REQ-006 SHALL have port in_valid, input, 1: a/is_signed/rm qualify this cycle.
REQ-007 SHALL have port a, input, 32: IEEE-754 binary32 operand.
REQ-008 SHALL have port is_signed, input, 1: 1 gives a two's-complement result, 0 gives an unsigned result.
REQ-009 SHALL have port rm, input, 1: rounding mode, 0 = round toward zero, 1 = round to nearest, ties to even.
REQ-010 SHALL have port out_valid, output, 1: q (and flags) valid.
REQ-011 SHALL have port q, output, OUT_WIDTH: converted integer.
REQ-012 SHALL have port fflags, output, 2: {invalid, inexact}; present only under FP_TO_INT_FLAGS_EN.

Function
REQ-013 SHALL accept an operand when en=1 and in_valid=1, and present the result with out_valid=1 exactly LATENCY en=1 cycles later.
REQ-014 SHALL hold all stage registers, including valid bits, when en=0; q/out_valid stay stable.
REQ-015 SHALL propagate in_valid=0 as a bubble; q is don't-care when out_valid=0 but SHALL NOT change on a bubble at stage 0.
REQ-016 SHALL sustain one conversion per cycle with back-to-back in_valid and no bubbles inserted.
REQ-017 SHALL round per rm: rtz truncates magnitude; rne rounds half to even using guard plus sticky bits.
REQ-018 SHALL convert +/-0 and denormals to 0; a nonzero denormal sets inexact.
REQ-019 SHALL treat signed range overflow: +overflow/+Inf/NaN -> 2^(OUT_WIDTH-1)-1, -overflow/-Inf -> -2^(OUT_WIDTH-1), each with invalid=1, inexact=0.
REQ-020 SHALL treat unsigned range overflow: +overflow/+Inf/NaN -> all-ones; any negative value that rounds to nonzero, or -Inf -> 0, with invalid=1.
REQ-021 SHALL return 0 with inexact=1, invalid=0 for an unsigned negative value rounding to zero (e.g. -0.3).
REQ-022 SHALL evaluate range after rounding (e.g. 2147483647.5 is unreachable in binary32; 2^31 signed is overflow, -2^31 signed is exact).
REQ-023 SHALL set inexact=1 iff any discarded fraction bit is nonzero and invalid=0.

Reset
REQ-024 SHALL clear all valid bits, q to 0 and fflags to 0 asynchronously while areset=0, regardless of en.
REQ-025 SHALL discard in-flight operations on reset mid-operation; first out_valid after release is LATENCY en-cycles after the first accepted operand.

Configuration
REQ-026 SHALL, with FP_TO_INT_FLAGS_EN defined, compute, pipeline and output fflags aligned with q.
REQ-027 SHALL, without FP_TO_INT_FLAGS_EN, omit the fflags port and its flag logic/registers; q and saturation behaviour SHALL be unchanged.

Structure
REQ-028 SHALL place the rounding-mode encoding constants (RM_RTZ, RM_RNE), the flag bit indices and binary32 field-width constants in shared package fp_pkg.
REQ-029 SHALL implement the conversion as combinational sub-module fp_to_int_core (a, is_signed, rm -> result, flags), registered at stage 0, then a LATENCY-1 deep en-gated delay line.

Verification
REQ-030 SHALL verify: a=0x40490FDB, signed, rtz -> q=3, inexact=1, invalid=0, out_valid after 3 cycles.
REQ-031 SHALL verify: a=0xC0200000 (-2.5), signed, rne -> q=0xFFFFFFFE; a=0x40600000 (3.5), rne -> q=4; both inexact=1.
REQ-032 SHALL verify: a=0x4F000000 (2^31), signed -> q=0x7FFFFFFF, invalid=1; a=0x7FC00000 (NaN) -> 0x7FFFFFFF, invalid=1; a=0xCF000000 -> 0x80000000, invalid=0.
REQ-033 SHALL verify: a=0xBF800000 (-1.0), unsigned -> q=0, invalid=1; a=0xBE99999A (-0.3), unsigned -> q=0, inexact=1, invalid=0.
REQ-034 SHALL verify: 10 back-to-back operands with en dropped for 2 cycles mid-stream -> results in order, none lost or duplicated, q frozen during en=0.
REQ-035 SHALL verify: areset asserted with 3 operations in flight -> out_valid=0 and q=0 immediately; no stale result emerges after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and helpers for binary32-to-integer conversion.
// Rounding-mode encodings, flag bit positions and binary32 field geometry.
package fp_pkg;

    localparam logic RM_RTZ = 1'b0;
    localparam logic RM_RNE = 1'b1;

    localparam int FLAG_INVALID = 1;
    localparam int FLAG_INEXACT = 0;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    // Magnitude datapath is wide enough for the largest in-range-or-just-over value (< 2^66).
    localparam int MAG_W = 67;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_e;

    function automatic fp_class_e fp_classify(input logic [EXP_W-1:0] exp_f, input logic [MAN_W-1:0] man_f);
        fp_class_e cls;
        if (exp_f == 8'h00) begin
            cls = CLS_ZERO;
        end else if (exp_f != 8'hFF) begin
            cls = CLS_NORMAL;
        end else if (man_f == 23'd0) begin
            cls = CLS_INF;
        end else begin
            cls = CLS_NAN;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_to_int_core.sv
// Combinational binary32 -> integer converter with rounding and saturation.
// The flags output exists only when FP_TO_INT_FLAGS_EN is defined.
module fp_to_int_core
    import fp_pkg::*;
#(
    parameter int OUT_WIDTH = 32
) (
    input  logic [31:0]          a,
    input  logic                 is_signed,
    input  logic                 rm,
`ifdef FP_TO_INT_FLAGS_EN
    output logic [1:0]           flags,
`endif
    output logic [OUT_WIDTH-1:0] result
);

    localparam logic [MAG_W-1:0] ONE_MAG = {{(MAG_W-1){1'b0}}, 1'b1};

    logic                    sign_s;
    logic [EXP_W-1:0]        exp_s;
    logic [MAN_W-1:0]        man_s;
    logic [MAN_W:0]          sig_s;
    fp_class_e               cls_s;
    logic signed [9:0]       unb_s;
    logic [5:0]              lsh_s;
    logic [4:0]              rsh_s;
    logic [47:0]             wide_s;
    logic [MAG_W-1:0]        mag_s;
    logic [MAG_W-1:0]        mag_rnd_s;
    logic [MAG_W-1:0]        pos_lim_s;
    logic [MAG_W-1:0]        neg_lim_s;
    logic                    guard_s;
    logic                    sticky_s;
    logic                    huge_s;
    logic                    round_up_s;
    logic                    ovf_s;
    logic [OUT_WIDTH-1:0]    max_res_s;
    logic [OUT_WIDTH-1:0]    min_res_s;

    assign sign_s = a[31];
    assign exp_s  = a[30:23];
    assign man_s  = a[22:0];
    assign sig_s  = {1'b1, man_s};
    assign cls_s  = fp_classify(exp_s, man_s);
    assign unb_s  = signed'({2'b00, exp_s}) - signed'(10'(EXP_BIAS));
    assign lsh_s  = 6'(unb_s - 10'sd23);
    assign rsh_s  = 5'(10'sd23 - unb_s);

    // Align the significand to an integer magnitude plus guard and sticky bits.
    always_comb begin
        mag_s    = '0;
        wide_s   = '0;
        guard_s  = 1'b0;
        sticky_s = 1'b0;
        huge_s   = 1'b0;
        if (unb_s > 10'sd64) begin
            huge_s = 1'b1;
        end else if (unb_s >= 10'sd23) begin
            mag_s = {{(MAG_W-24){1'b0}}, sig_s} << lsh_s;
        end else if (unb_s >= -10'sd1) begin
            wide_s   = {sig_s, 24'b0} >> rsh_s;
            mag_s    = {{(MAG_W-24){1'b0}}, wide_s[47:24]};
            guard_s  = wide_s[23];
            sticky_s = |wide_s[22:0];
        end else begin
            // Below one half: nothing survives except the sticky indication.
            sticky_s = 1'b1;
        end
    end

    assign round_up_s = (rm == RM_RNE) && guard_s && (sticky_s || mag_s[0]);
    assign mag_rnd_s  = mag_s + {{(MAG_W-1){1'b0}}, round_up_s};

    assign pos_lim_s = is_signed ? ((ONE_MAG << (OUT_WIDTH-1)) - ONE_MAG) : ((ONE_MAG << OUT_WIDTH) - ONE_MAG);
    assign neg_lim_s = is_signed ? (ONE_MAG << (OUT_WIDTH-1)) : {MAG_W{1'b0}};
    assign ovf_s     = huge_s || (sign_s ? (mag_rnd_s > neg_lim_s) : (mag_rnd_s > pos_lim_s));

    assign max_res_s = is_signed ? {1'b0, {(OUT_WIDTH-1){1'b1}}} : {OUT_WIDTH{1'b1}};
    assign min_res_s = is_signed ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {OUT_WIDTH{1'b0}};

    // Select the saturated or rounded integer result by operand class.
    always_comb begin
        result = '0;
        case (cls_s)
            CLS_ZERO:   result = '0;
            CLS_NAN:    result = max_res_s;
            CLS_INF:    result = sign_s ? min_res_s : max_res_s;
            CLS_NORMAL: begin
                if (ovf_s) begin
                    result = sign_s ? min_res_s : max_res_s;
                end else if (sign_s) begin
                    result = -mag_rnd_s[OUT_WIDTH-1:0];
                end else begin
                    result = mag_rnd_s[OUT_WIDTH-1:0];
                end
            end
            default:    result = '0;
        endcase
    end

`ifdef FP_TO_INT_FLAGS_EN
    // Invalid on any saturation; inexact only for an in-range result that lost bits.
    always_comb begin
        flags = 2'b00;
        case (cls_s)
            CLS_ZERO: flags[FLAG_INEXACT] = |man_s;
            CLS_NAN,
            CLS_INF:  flags[FLAG_INVALID] = 1'b1;
            CLS_NORMAL: begin
                if (ovf_s) begin
                    flags[FLAG_INVALID] = 1'b1;
                end else begin
                    flags[FLAG_INEXACT] = guard_s | sticky_s;
                end
            end
            default:  flags = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/fp_to_int_pipe.sv
// Pipelined binary32 -> integer converter: combinational core, stage-0 register, en-gated delay line.
// Define FP_TO_INT_FLAGS_EN to add the {invalid, inexact} fflags output.
module fp_to_int_pipe
    import fp_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [31:0]          a,
    input  logic                 is_signed,
    input  logic                 rm,
    output logic                 out_valid,
`ifdef FP_TO_INT_FLAGS_EN
    output logic [1:0]           fflags,
`endif
    output logic [OUT_WIDTH-1:0] q
);

    logic [OUT_WIDTH-1:0] core_result_s;
    logic [LATENCY-1:0]   valid_r;
    logic [OUT_WIDTH-1:0] data_r [LATENCY];
`ifdef FP_TO_INT_FLAGS_EN
    logic [1:0]           core_flags_s;
    logic [1:0]           flags_r [LATENCY];
`endif

    fp_to_int_core #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .a         (a),
        .is_signed (is_signed),
        .rm        (rm),
`ifdef FP_TO_INT_FLAGS_EN
        .flags     (core_flags_s),
`endif
        .result    (core_result_s)
    );

    // Valid bits advance on every enabled cycle so bubbles travel with the data.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            valid_r <= '0;
        end else if (en) begin
            valid_r[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end
    end

    // Stage 0 only loads on a real operand, so a bubble leaves the data untouched.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int i = 0; i < LATENCY; i++) begin
                data_r[i] <= '0;
            end
        end else if (en) begin
            if (in_valid) begin
                data_r[0] <= core_result_s;
            end
            for (int i = 1; i < LATENCY; i++) begin
                data_r[i] <= data_r[i-1];
            end
        end
    end

`ifdef FP_TO_INT_FLAGS_EN
    // Flags ride alongside the data so they stay aligned with q.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int i = 0; i < LATENCY; i++) begin
                flags_r[i] <= 2'b00;
            end
        end else if (en) begin
            if (in_valid) begin
                flags_r[0] <= core_flags_s;
            end
            for (int i = 1; i < LATENCY; i++) begin
                flags_r[i] <= flags_r[i-1];
            end
        end
    end

    assign fflags = flags_r[LATENCY-1];
`endif

    assign out_valid = valid_r[LATENCY-1];
    assign q         = data_r[LATENCY-1];

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Directed bench for fp_to_int_pipe: vector table, en-freeze stream and mid-flight reset.
module tb_fp_to_int_pipe;

    localparam int LAT = 3;

    typedef struct {
        logic [31:0] a;
        logic        sgn;
        logic        rm;
        logic [31:0] q;
        logic [1:0]  fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        areset;
    logic        en;
    logic        in_valid;
    logic [31:0] a;
    logic        is_signed;
    logic        rm;
    logic        out_valid;
    logic [31:0] q;
`ifdef FP_TO_INT_FLAGS_EN
    logic [1:0]  fflags;
`endif

    int checks   = 0;
    int failures = 0;

    logic        mon_on = 1'b0;
    logic [31:0] got_q[$];

    vec_t        vecs[28];
    logic [31:0] ints[10];

    always #5 clk = ~clk;

    fp_to_int_pipe #(
        .LATENCY   (LAT),
        .OUT_WIDTH (32)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .is_signed (is_signed),
        .rm        (rm),
        .out_valid (out_valid),
`ifdef FP_TO_INT_FLAGS_EN
        .fflags    (fflags),
`endif
        .q         (q)
    );

    // Consumer model: a result is taken on each enabled edge while out_valid is high.
    always @(negedge clk) begin
        if (mon_on && en && out_valid) got_q.push_back(q);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [31:0] av, input logic s, input logic r,
                           output int lat, output logic [31:0] qv, output logic [1:0] fv);
        a = av; is_signed = s; rm = r; in_valid = 1'b1;
        lat = 0; qv = '0; fv = '0;
        for (int c = 1; c <= 8; c++) begin
            step();
            in_valid = 1'b0;
            if (out_valid && lat == 0) begin
                lat = c;
                qv  = q;
`ifdef FP_TO_INT_FLAGS_EN
                fv  = fflags;
`endif
            end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] qv;
        logic [1:0]  fv;
        logic [31:0] qhold;
        logic        vhold;
        int          vcount;

        vecs[0]  = '{32'h40490FDB, 1'b1, 1'b0, 32'h00000003, 2'b01};
        vecs[1]  = '{32'hC0200000, 1'b1, 1'b1, 32'hFFFFFFFE, 2'b01};
        vecs[2]  = '{32'h40600000, 1'b1, 1'b1, 32'h00000004, 2'b01};
        vecs[3]  = '{32'h4F000000, 1'b1, 1'b0, 32'h7FFFFFFF, 2'b10};
        vecs[4]  = '{32'h7FC00000, 1'b1, 1'b0, 32'h7FFFFFFF, 2'b10};
        vecs[5]  = '{32'hCF000000, 1'b1, 1'b0, 32'h80000000, 2'b00};
        vecs[6]  = '{32'hBF800000, 1'b0, 1'b0, 32'h00000000, 2'b10};
        vecs[7]  = '{32'hBE99999A, 1'b0, 1'b0, 32'h00000000, 2'b01};
        vecs[8]  = '{32'h00000000, 1'b1, 1'b1, 32'h00000000, 2'b00};
        vecs[9]  = '{32'h80000001, 1'b1, 1'b1, 32'h00000000, 2'b01};
        vecs[10] = '{32'hFF800000, 1'b1, 1'b0, 32'h80000000, 2'b10};
        vecs[11] = '{32'h7F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 2'b10};
        vecs[12] = '{32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 2'b10};
        vecs[13] = '{32'h4F7FFFFF, 1'b0, 1'b1, 32'hFFFFFF00, 2'b00};
        vecs[14] = '{32'h3FC00000, 1'b1, 1'b1, 32'h00000002, 2'b01};
        vecs[15] = '{32'h3FC00000, 1'b1, 1'b0, 32'h00000001, 2'b01};
        vecs[16] = '{32'h3F000000, 1'b1, 1'b1, 32'h00000000, 2'b01};
        vecs[17] = '{32'h3F400000, 1'b1, 1'b1, 32'h00000001, 2'b01};
        vecs[18] = '{32'h40200000, 1'b1, 1'b1, 32'h00000002, 2'b01};
        vecs[19] = '{32'h4B000001, 1'b1, 1'b0, 32'h00800001, 2'b00};
        vecs[20] = '{32'hC2F60000, 1'b1, 1'b0, 32'hFFFFFF85, 2'b00};
        vecs[21] = '{32'hCF000001, 1'b1, 1'b0, 32'h80000000, 2'b10};
        vecs[22] = '{32'h4EFFFFFF, 1'b1, 1'b1, 32'h7FFFFF80, 2'b00};
        vecs[23] = '{32'hBF333333, 1'b0, 1'b1, 32'h00000000, 2'b10};
        vecs[24] = '{32'hBF000000, 1'b0, 1'b1, 32'h00000000, 2'b01};
        vecs[25] = '{32'hBF400000, 1'b1, 1'b1, 32'hFFFFFFFF, 2'b01};
        vecs[26] = '{32'hFF800000, 1'b0, 1'b0, 32'h00000000, 2'b10};
        vecs[27] = '{32'h4F000000, 1'b0, 1'b0, 32'h80000000, 2'b00};

        ints = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};

        areset = 1'b0; en = 1'b0; in_valid = 1'b0; a = '0; is_signed = 1'b1; rm = 1'b0;
        step();
        step();
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_q", {32'd0, q}, 64'd0);
        areset = 1'b1;
        en     = 1'b1;
        step();

        for (int i = 0; i < 28; i++) begin
            run_one(vecs[i].a, vecs[i].sgn, vecs[i].rm, lat, qv, fv);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("vec%0d_q", i), {32'd0, qv}, {32'd0, vecs[i].q});
`ifdef FP_TO_INT_FLAGS_EN
            check($sformatf("vec%0d_flags", i), {62'd0, fv}, {62'd0, vecs[i].fl});
`endif
        end

        // Back-to-back stream with a two-cycle en freeze in the middle.
        got_q.delete();
        mon_on = 1'b1;
        is_signed = 1'b1; rm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                en    = 1'b0;
                qhold = q;
                vhold = out_valid;
                for (int k = 0; k < 2; k++) begin
                    step();
                    check($sformatf("freeze%0d_q", k), {32'd0, q}, {32'd0, qhold});
                    check($sformatf("freeze%0d_valid", k), {63'd0, out_valid}, {63'd0, vhold});
                end
                en = 1'b1;
            end
            a = ints[i];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) step();
        mon_on = 1'b0;
        check("stream_count", 64'(got_q.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) check($sformatf("stream%0d_q", i), {32'd0, got_q[i]}, 64'(i + 1));
        end

        // Reset with three operations in flight.
        for (int k = 0; k < 3; k++) begin
            a = ints[6 + k];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        check("pre_reset_q", {32'd0, q}, 64'd7);
        areset = 1'b0;
        #1;
        check("mid_reset_valid", {63'd0, out_valid}, 64'd0);
        check("mid_reset_q", {32'd0, q}, 64'd0);
`ifdef FP_TO_INT_FLAGS_EN
        check("mid_reset_flags", {62'd0, fflags}, 64'd0);
`endif
        step();
        step();
        areset = 1'b1;
        vcount = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid) vcount++;
        end
        check("post_reset_stale", 64'(vcount), 64'd0);
        run_one(ints[1], 1'b1, 1'b0, lat, qv, fv);
        check("post_reset_latency", 64'(lat), 64'(LAT));
        check("post_reset_q", {32'd0, qv}, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
